// File: rtl/qspi_tgt_pkg.sv
// Shared definitions for the QSPI target: opcodes, FSM states, lane modes.
package qspi_tgt_pkg;

    localparam logic [7:0] OP_WR1 = 8'h02;
    localparam logic [7:0] OP_RD1 = 8'h03;
    localparam logic [7:0] OP_WR4 = 8'h32;
    localparam logic [7:0] OP_RD4 = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    typedef enum logic {
        LANE_1,
        LANE_4
    } lane_e;

    // SCK rises needed to move `bits` bits over the given lane width.
    function automatic logic [7:0] phase_rises(lane_e lane, int unsigned bits);
        return (lane == LANE_4) ? 8'(bits / 4) : 8'(bits);
    endfunction

endpackage

// File: rtl/qspi_tgt_if.sv
// QSPI pin bundle plus the local byte-wide memory port of the target.
interface qspi_tgt_if #(parameter int AW = 8);

    logic          qspi_sck;
    logic          qspi_csn;
    logic [3:0]    qspi_dq_i;
    logic [3:0]    qspi_dq_o;
    logic [3:0]    qspi_dq_en;
    logic          tgt_wr_vld;
    logic [AW-1:0] tgt_wr_addr;
    logic [7:0]    tgt_wr_dat;
    logic          tgt_rd_req;
    logic [AW-1:0] tgt_rd_addr;
    logic [7:0]    tgt_rd_dat;
    logic          tgt_busy;
    logic          tgt_err;

    modport slave (
        input  qspi_sck, qspi_csn, qspi_dq_i, tgt_rd_dat,
        output qspi_dq_o, qspi_dq_en, tgt_wr_vld, tgt_wr_addr, tgt_wr_dat,
               tgt_rd_req, tgt_rd_addr, tgt_busy, tgt_err
    );

    modport master (
        output qspi_sck, qspi_csn, qspi_dq_i, tgt_rd_dat,
        input  qspi_dq_o, qspi_dq_en, tgt_wr_vld, tgt_wr_addr, tgt_wr_dat,
               tgt_rd_req, tgt_rd_addr, tgt_busy, tgt_err
    );

endinterface

// File: rtl/qspi_tgt_sync.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width and reset value.
module qspi_tgt_sync #(
    parameter int   W       = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= {W{RST_VAL}};
            q    <= {W{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qspi_tgt.sv
// QSPI target engine: oversamples SCK/CSN/DQ, decodes cmd/addr/dummy phases and
// converts data phases into byte writes and byte-read requests on the local port.
module qspi_tgt
    import qspi_tgt_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DUMMY_CYC = 4
) (
    input logic       clk,
    input logic       rst_n,
    qspi_tgt_if.slave bus
);

    logic          sck_s, csn_s, sck_q, csn_q, csn_armed;
    logic [3:0]    dq_s;
    logic          sck_rise, sck_fall, csn_fall, phase_last, op_known;
    state_e        state, state_d;
    lane_e         lane;
    logic [7:0]    cnt, need, sh, op, cmd_byte, data_shift, rd_sh;
    logic [AW-1:0] addr, addr_shift;
    logic          rd_pend;
    logic [3:0]    dq_o, dq_en;

    // CSN resets low in the synchronizer so a reset can never fabricate a falling edge;
    // csn_armed keeps busy low until a real high level has been seen.
    qspi_tgt_sync #(.W(1), .RST_VAL(1'b0)) u_sync_sck (.clk(clk), .rst_n(rst_n), .d(bus.qspi_sck), .q(sck_s));
    qspi_tgt_sync #(.W(1), .RST_VAL(1'b0)) u_sync_csn (.clk(clk), .rst_n(rst_n), .d(bus.qspi_csn), .q(csn_s));
    qspi_tgt_sync #(.W(4), .RST_VAL(1'b0)) u_sync_dq  (.clk(clk), .rst_n(rst_n), .d(bus.qspi_dq_i), .q(dq_s));

    assign sck_rise   = sck_s & ~sck_q;
    assign sck_fall   = ~sck_s & sck_q;
    assign csn_fall   = csn_q & ~csn_s;
    assign cmd_byte   = {sh[6:0], dq_s[0]};
    assign op_known   = cmd_byte inside {OP_WR1, OP_RD1, OP_WR4, OP_RD4};
    assign data_shift = (lane == LANE_4) ? ((sh << 4) | {4'b0, dq_s}) : ((sh << 1) | {7'b0, dq_s[0]});
    assign addr_shift = (lane == LANE_4) ? ((addr << 4) | AW'(dq_s)) : ((addr << 1) | AW'(dq_s[0]));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        need    = 8'd8;
        state_d = state;
        case (state)
            ST_ADDR:            need = phase_rises(lane, AW);
            ST_DUMMY:           need = 8'(DUMMY_CYC);
            ST_WDATA, ST_RDATA: need = phase_rises(lane, 8);
            default:            need = 8'd8;
        endcase
        phase_last = sck_rise && (cnt == need - 8'd1);

        case (state)
            ST_IDLE:  if (csn_fall) state_d = ST_CMD;
            ST_CMD:   if (phase_last) state_d = op_known ? ST_ADDR : ST_IGNORE;
            ST_ADDR:
                if (phase_last) begin
                    if (op == OP_WR1 || op == OP_WR4) state_d = ST_WDATA;
                    else if (op == OP_RD4)            state_d = ST_DUMMY;
                    else                              state_d = ST_RDATA;
                end
            ST_DUMMY: if (phase_last) state_d = ST_RDATA;
            default:  state_d = state;
        endcase

        // A deasserted CSN overrides any SCK edge seen in the same clock.
        if (csn_s) state_d = ST_IDLE;

        dq_en = 4'b0000;
        if (state == ST_RDATA) dq_en = (lane == LANE_4) ? 4'b1111 : 4'b0010;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q            <= 1'b0;
            csn_q            <= 1'b0;
            csn_armed        <= 1'b0;
            cnt              <= '0;
            sh               <= '0;
            op               <= '0;
            lane             <= LANE_1;
            addr             <= '0;
            rd_sh            <= '0;
            rd_pend          <= 1'b0;
            dq_o             <= '0;
            bus.tgt_wr_vld   <= 1'b0;
            bus.tgt_wr_addr  <= '0;
            bus.tgt_wr_dat   <= '0;
            bus.tgt_rd_req   <= 1'b0;
            bus.tgt_rd_addr  <= '0;
            bus.tgt_err      <= 1'b0;
        end else begin
            sck_q          <= sck_s;
            csn_q          <= csn_s;
            bus.tgt_wr_vld <= 1'b0;
            bus.tgt_rd_req <= 1'b0;
            bus.tgt_err    <= 1'b0;
            rd_pend        <= bus.tgt_rd_req;
            if (csn_s) csn_armed <= 1'b1;

            if (csn_s) begin
                cnt     <= '0;
                rd_pend <= 1'b0;
                dq_o    <= '0;
            end else begin
                if (state_d != state || phase_last) cnt <= '0;
                else if (sck_rise)                  cnt <= cnt + 8'd1;

                case (state)
                    ST_CMD: begin
                        if (sck_rise) sh <= cmd_byte;
                        if (phase_last) begin
                            op          <= cmd_byte;
                            lane        <= (cmd_byte == OP_WR4 || cmd_byte == OP_RD4) ? LANE_4 : LANE_1;
                            bus.tgt_err <= !op_known;
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) addr <= addr_shift;
                        if (phase_last && state_d == ST_RDATA) begin
                            bus.tgt_rd_req  <= 1'b1;
                            bus.tgt_rd_addr <= addr_shift;
                        end
                    end
                    ST_DUMMY: begin
                        if (phase_last) begin
                            bus.tgt_rd_req  <= 1'b1;
                            bus.tgt_rd_addr <= addr;
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) sh <= data_shift;
                        if (phase_last) begin
                            bus.tgt_wr_vld  <= 1'b1;
                            bus.tgt_wr_addr <= addr;
                            bus.tgt_wr_dat  <= data_shift;
                            addr            <= addr + 1'b1;
                        end
                    end
                    ST_RDATA: begin
                        if (rd_pend) begin
                            rd_sh <= bus.tgt_rd_dat;
                        end else if (sck_fall) begin
                            dq_o  <= (lane == LANE_4) ? rd_sh[7:4] : {2'b00, rd_sh[7], 1'b0};
                            rd_sh <= (lane == LANE_4) ? (rd_sh << 4) : (rd_sh << 1);
                        end
                        if (phase_last) begin
                            addr            <= addr + 1'b1;
                            bus.tgt_rd_req  <= 1'b1;
                            bus.tgt_rd_addr <= addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.qspi_dq_o  = dq_o;
    assign bus.qspi_dq_en = dq_en;
    assign bus.tgt_busy   = csn_armed & ~csn_s;

endmodule

// File: tb/tb_qspi_tgt.sv
// Directed + randomized bench for qspi_tgt: an initiator model drives SCK/CSN/DQ,
// a byte memory answers reads, and expectations come from a transaction-level model.
module tb_qspi_tgt;
    import qspi_tgt_pkg::*;

    localparam int AW        = 8;
    localparam int DUMMY_CYC = 4;
    localparam int HALF      = 60;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qspi_tgt_if #(.AW(AW)) ifc ();

    qspi_tgt #(.AW(AW), .DUMMY_CYC(DUMMY_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]      mem [256];
    logic [AW-1:0]   rd_log [$];
    logic [AW+7:0]   wr_log [$];
    logic [7:0]      wq [$];
    int              err_cnt;
    logic [3:0]      en_or, cyc_en_or;
    logic [AW-1:0]   resp_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Local memory: answers a read request with data valid exactly one clock later.
    always @(negedge clk) begin
        if (ifc.tgt_rd_req) begin
            resp_addr = ifc.tgt_rd_addr;
            rd_log.push_back(resp_addr);
            @(posedge clk);
            #1 ifc.tgt_rd_dat = mem[resp_addr];
            @(posedge clk);
            #1 ifc.tgt_rd_dat = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (ifc.tgt_wr_vld) wr_log.push_back({ifc.tgt_wr_addr, ifc.tgt_wr_dat});
        if (ifc.tgt_err) err_cnt++;
        en_or = en_or | ifc.qspi_dq_en;
    end

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        err_cnt   = 0;
        en_or     = 4'b0;
        cyc_en_or = 4'b0;
    endtask

    // One SCK period: present DQ, sample the target's drive just before the rise.
    task automatic spi_cycle(input logic [3:0] dq, output logic [3:0] seen_dq, output logic [3:0] seen_en);
        ifc.qspi_dq_i = dq;
        #HALF;
        seen_dq = ifc.qspi_dq_o;
        seen_en = ifc.qspi_dq_en;
        ifc.qspi_sck = 1'b1;
        #HALF;
        ifc.qspi_sck = 1'b0;
    endtask

    task automatic tx_bits(input logic [31:0] val, input int nbits, input bit quad);
        logic [3:0] sd, se;
        if (quad) begin
            for (int i = nbits / 4 - 1; i >= 0; i--) begin
                spi_cycle(4'(val >> (4 * i)), sd, se);
                cyc_en_or |= se;
            end
        end else begin
            for (int i = nbits - 1; i >= 0; i--) begin
                spi_cycle({3'b000, val[i]}, sd, se);
                cyc_en_or |= se;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] op, input logic [7:0] a);
        bit quad = (op == OP_WR4);
        int n;
        clear_logs();
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(op, 8, 1'b0);
        tx_bits(a, AW, quad);
        foreach (wq[i]) tx_bits(wq[i], 8, quad);
        #HALF ifc.qspi_csn = 1'b1;
        #(4 * HALF);
        check("wr count", wr_log.size(), wq.size());
        n = (wr_log.size() < wq.size()) ? wr_log.size() : wq.size();
        for (int i = 0; i < n; i++) begin
            check("wr addr", wr_log[i][AW+7:8], (int'(a) + i) % 256);
            check("wr data", wr_log[i][7:0], wq[i]);
        end
        check("wr dq_en", en_or | cyc_en_or, 0);
        check("wr no rd_req", rd_log.size(), 0);
        check("wr no err", err_cnt, 0);
    endtask

    task automatic do_read(input logic [7:0] op, input logic [7:0] a, input int nbytes);
        bit quad = (op == OP_RD4);
        logic [7:0] e;
        logic [3:0] sd, se;
        int n;
        clear_logs();
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(op, 8, 1'b0);
        tx_bits(a, AW, quad);
        if (quad) for (int d = 0; d < DUMMY_CYC; d++) tx_bits($urandom, 4, 1'b1);
        check("rd pre-data dq_en", cyc_en_or, 0);
        for (int b = 0; b < nbytes; b++) begin
            e = mem[(int'(a) + b) % 256];
            for (int k = 0; k < (quad ? 2 : 8); k++) begin
                spi_cycle(4'($urandom), sd, se);
                if (quad) begin
                    check("quad rd nibble", sd, (e >> (4 * (1 - k))) & 8'h0F);
                    check("quad rd dq_en", se, 4'b1111);
                end else begin
                    check("single rd dq1", sd[1], e[7-k]);
                    check("single rd dq_en", se, 4'b0010);
                end
            end
        end
        #HALF ifc.qspi_csn = 1'b1;
        #(4 * HALF);
        check("rd dq_en after csn", ifc.qspi_dq_en, 0);
        check("rd req count", rd_log.size(), nbytes + 1);
        n = (rd_log.size() < nbytes + 1) ? rd_log.size() : nbytes + 1;
        for (int i = 0; i < n; i++) check("rd req addr", rd_log[i], (int'(a) + i) % 256);
        check("rd no wr_vld", wr_log.size(), 0);
        check("rd no err", err_cnt, 0);
    endtask

    logic [7:0] r_op, r_addr;
    logic [3:0] sd0, se0;
    int         r_n;

    initial begin
        ifc.qspi_csn   = 1'b1;
        ifc.qspi_sck   = 1'b0;
        ifc.qspi_dq_i  = 4'h0;
        ifc.tgt_rd_dat = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        clear_logs();

        #23;
        check("rst dq_en", ifc.qspi_dq_en, 0);
        check("rst dq_o", ifc.qspi_dq_o, 0);
        check("rst wr_vld", ifc.tgt_wr_vld, 0);
        check("rst rd_req", ifc.tgt_rd_req, 0);
        check("rst wr_addr", ifc.tgt_wr_addr, 0);
        check("rst rd_addr", ifc.tgt_rd_addr, 0);
        check("rst busy", ifc.tgt_busy, 0);
        check("rst err", ifc.tgt_err, 0);
        check("rst state", dut.state, ST_IDLE);
        #10 rst_n = 1'b1;
        #(2 * HALF);

        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
        do_write(OP_WR1, 8'h10);

        mem[8'h40] = 8'hC3;
        do_read(OP_RD1, 8'h40, 1);

        mem[8'h20] = 8'h5A; mem[8'h21] = 8'h96;
        do_read(OP_RD4, 8'h20, 2);

        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(OP_WR4, 8'hFF);

        // Abort: one full byte, then CSN rises after 5 bits of the second.
        clear_logs();
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(OP_WR1, 8, 1'b0);
        tx_bits(8'h7E, AW, 1'b0);
        tx_bits(8'h9D, 8, 1'b0);
        tx_bits(5'h15, 5, 1'b0);
        ifc.qspi_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort wr dq_en", ifc.qspi_dq_en, 0);
        check("abort wr state", dut.state, ST_IDLE);
        #(4 * HALF);
        check("abort wr count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("abort wr first", wr_log[0], {8'h7E, 8'h9D});
        check("abort wr busy", ifc.tgt_busy, 0);

        // Abort during read data: drive must stop within 3 clocks of CSN rising.
        clear_logs();
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(OP_RD4, 8, 1'b0);
        tx_bits(8'h33, AW, 1'b1);
        tx_bits(16'h0, 4 * DUMMY_CYC, 1'b1);
        spi_cycle(4'h0, sd0, se0);
        check("abort rd en active", se0, 4'b1111);
        ifc.qspi_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort rd dq_en", ifc.qspi_dq_en, 0);
        check("abort rd state", dut.state, ST_IDLE);
        #(4 * HALF);

        // Unknown opcode: one err pulse, then silence until CSN rises.
        clear_logs();
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(8'h9F, 8, 1'b0);
        tx_bits($urandom, 16, 1'b0);
        check("unk err pulses", err_cnt, 1);
        check("unk no rd_req", rd_log.size(), 0);
        check("unk no wr_vld", wr_log.size(), 0);
        check("unk dq_en", en_or | cyc_en_or, 0);
        ifc.qspi_csn = 1'b1;
        #(4 * HALF);
        check("unk err after csn", err_cnt, 1);
        do_read(OP_RD1, 8'($urandom), 1);

        // Asynchronous reset mid-read; CSN held low afterwards must not start a transfer.
        ifc.qspi_csn = 1'b0;
        #HALF;
        tx_bits(OP_RD1, 8, 1'b0);
        tx_bits(8'h55, AW, 1'b0);
        tx_bits(3'h0, 3, 1'b0);
        #7 rst_n = 1'b0;
        #1;
        check("midrst dq_en", ifc.qspi_dq_en, 0);
        check("midrst busy", ifc.tgt_busy, 0);
        check("midrst rd_addr", ifc.tgt_rd_addr, 0);
        check("midrst state", dut.state, ST_IDLE);
        #22 rst_n = 1'b1;
        clear_logs();
        tx_bits(OP_WR1, 8, 1'b0);
        tx_bits(24'h12_3456, 24, 1'b0);
        check("postrst no wr", wr_log.size(), 0);
        check("postrst no rd", rd_log.size(), 0);
        check("postrst busy", ifc.tgt_busy, 0);
        check("postrst dq_en", en_or, 0);
        ifc.qspi_csn = 1'b1;
        #(4 * HALF);

        for (int t = 0; t < 8; t++) begin
            r_addr = 8'($urandom);
            r_n    = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0:       r_op = OP_WR1;
                1:       r_op = OP_WR4;
                2:       r_op = OP_RD1;
                default: r_op = OP_RD4;
            endcase
            if (r_op == OP_WR1 || r_op == OP_WR4) begin
                wq.delete();
                for (int i = 0; i < r_n; i++) wq.push_back(8'($urandom));
                do_write(r_op, r_addr);
            end else begin
                for (int i = 0; i < r_n; i++) mem[(int'(r_addr) + i) % 256] = 8'($urandom);
                do_read(r_op, r_addr, r_n);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
